// File: rtl/fft_frame_ctrl_if.sv
// rtl/fft_frame_ctrl_if.sv - sample strobe, buffer write port and FFT handshake bundle
interface fft_frame_ctrl_if #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter int NOTE_W    = 8
);
  logic                 sample_valid;
  logic [BIT_WIDTH-1:0] sample_in;
  logic                 load_we;
  logic [N-1:0]         load_addr;
  logic [BIT_WIDTH-1:0] load_data;
  logic                 fft_start;
  logic                 fft_done;
  logic [NOTE_W-1:0]    fft_note;

  modport master (
    input  sample_valid, sample_in, fft_done, fft_note,
    output load_we, load_addr, load_data, fft_start
  );

  modport slave (
    output sample_valid, sample_in, fft_done, fft_note,
    input  load_we, load_addr, load_data, fft_start
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - button-debounced frame sequencer feeding the FFT, with note stability filter
module fft_frame_ctrl #(
  parameter int BIT_WIDTH     = 16,
  parameter int N             = 9,
  parameter int FFT_SIZE      = 512,
  parameter int NUM_BTN       = 4,
  parameter int NOTE_W        = 8,
  parameter int DB_CYCLES     = 1000,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT       = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic [NUM_BTN-1:0]         btn_n,
  fft_frame_ctrl_if.master           bus,
  output logic [NOTE_W-1:0]          note_out,
  output logic                       note_dec,
  output logic [$clog2(NUM_BTN)-1:0] active_btn,
  output logic                       led_load,
  output logic                       led_start,
  output logic                       timeout_err
);
  localparam int BW  = $clog2(NUM_BTN);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam int SW  = $clog2(STABLE_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, JUDGE} state_t;

  state_t             state;
  logic [N-1:0]       addr;
  logic [TOW-1:0]     to_cnt;
  logic [NOTE_W-1:0]  cand;
  logic [SW-1:0]      cnt;
  logic [NOTE_W-1:0]  nxt_cand;
  logic [SW-1:0]      nxt_cnt;
  logic [NUM_BTN-1:0] pressed;
  logic [DBW-1:0]     db_cnt [NUM_BTN];
  logic [BW-1:0]      low_idx;

  // pressed[i] follows !btn_n[i] only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pressed <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!btn_n[i] == pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          pressed[i] <= !btn_n[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pressed[i]) low_idx = BW'(i);
    end
  end

  always_comb begin
    nxt_cand = bus.fft_note;
    nxt_cnt  = SW'(1);
    if (bus.fft_note == '0) begin
      nxt_cand = '0;
      nxt_cnt  = '0;
    end else if (bus.fft_note == cand) begin
      nxt_cnt = (cnt == SW'(STABLE_FRAMES)) ? cnt : cnt + SW'(1);
    end
  end

  assign led_load  = (state == LOAD);
  assign led_start = (state == START) || (state == WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      to_cnt        <= '0;
      cand          <= '0;
      cnt           <= '0;
      note_out      <= '0;
      note_dec      <= 1'b0;
      active_btn    <= '0;
      timeout_err   <= 1'b0;
      bus.load_we   <= 1'b0;
      bus.load_addr <= '0;
      bus.load_data <= '0;
      bus.fft_start <= 1'b0;
    end else begin
      bus.load_we   <= 1'b0;
      bus.fft_start <= 1'b0;
      note_dec      <= 1'b0;
      case (state)
        IDLE: begin
          cand <= '0;
          cnt  <= '0;
          if (|pressed) begin
            active_btn  <= low_idx;
            timeout_err <= 1'b0;
            addr        <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (!mode && !pressed[active_btn]) begin
            state <= IDLE;
          end else if (bus.sample_valid) begin
            bus.load_we   <= 1'b1;
            bus.load_addr <= addr;
            bus.load_data <= bus.sample_in;
            addr          <= addr + N'(1);
            if (addr == N'(FFT_SIZE - 1)) state <= START;
          end
        end
        START: begin
          bus.fft_start <= 1'b1;
          to_cnt        <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          // filter is evaluated on fft_done so note_out moves the cycle right after it
          if (bus.fft_done) begin
            cand <= nxt_cand;
            cnt  <= nxt_cnt;
            if (nxt_cnt == SW'(STABLE_FRAMES) && nxt_cand != note_out) begin
              note_out <= nxt_cand;
              note_dec <= 1'b1;
            end
            state <= JUDGE;
          end else if (to_cnt == TOW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TOW'(1);
          end
        end
        JUDGE: begin
          addr  <= '0;
          state <= (mode || pressed[active_btn]) ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - randomized self-checking bench for fft_frame_ctrl
module tb_fft_frame_ctrl;
  localparam int BIT_WIDTH     = 16;
  localparam int N             = 9;
  localparam int FFT_SIZE      = 512;
  localparam int NUM_BTN       = 4;
  localparam int NOTE_W        = 8;
  localparam int DB_CYCLES     = 8;
  localparam int STABLE_FRAMES = 2;
  localparam int TIMEOUT       = 200;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               mode = 1'b0;
  logic [NUM_BTN-1:0] btn_n = '1;
  logic [NOTE_W-1:0]  note_out;
  logic               note_dec;
  logic [1:0]         active_btn;
  logic               led_load, led_start, timeout_err;

  int                n_cmp = 0;
  int                n_err = 0;
  logic [NOTE_W-1:0] m_note = '0;
  int                m_hist[$];

  fft_frame_ctrl_if #(.BIT_WIDTH(BIT_WIDTH), .N(N), .NOTE_W(NOTE_W)) ifc ();

  fft_frame_ctrl #(
    .BIT_WIDTH(BIT_WIDTH), .N(N), .FFT_SIZE(FFT_SIZE), .NUM_BTN(NUM_BTN), .NOTE_W(NOTE_W),
    .DB_CYCLES(DB_CYCLES), .STABLE_FRAMES(STABLE_FRAMES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .btn_n(btn_n), .bus(ifc),
    .note_out(note_out), .note_dec(note_dec), .active_btn(active_btn),
    .led_load(led_load), .led_start(led_start), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // a note is accepted once the last STABLE_FRAMES judged frames of the session all carry it
  function automatic logic model_judge(input logic [NOTE_W-1:0] note);
    m_hist.push_back(int'(note));
    if (note == '0 || m_hist.size() < STABLE_FRAMES) return 1'b0;
    for (int k = 1; k <= STABLE_FRAMES; k++)
      if (m_hist[m_hist.size() - k] != int'(note)) return 1'b0;
    if (note == m_note) return 1'b0;
    m_note = note;
    return 1'b1;
  endfunction

  function automatic logic [NOTE_W-1:0] rand_note();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h45;
      2:       return 8'h47;
      default: return NOTE_W'($urandom_range(1, 255));
    endcase
  endfunction

  task automatic load_frame(input int count);
    logic [BIT_WIDTH-1:0] d;
    logic                 v;
    logic [N-1:0]         a;
    int                   i;
    a = '0;
    i = 0;
    while (i < count) begin
      v = ($urandom_range(0, 3) != 0);
      d = BIT_WIDTH'($urandom);
      ifc.sample_valid = v;
      ifc.sample_in    = d;
      @(negedge clk);
      n_cmp++;
      if (v) begin
        if (ifc.load_we !== 1'b1 || ifc.load_addr !== a || ifc.load_data !== d || note_dec !== 1'b0) begin
          n_err++;
          $display("FAIL write: we=%b addr=%0d data=%h dec=%b, required we=1 addr=%0d data=%h dec=0",
                   ifc.load_we, ifc.load_addr, ifc.load_data, note_dec, a, d);
        end
        a++;
        i++;
      end else if (ifc.load_we !== 1'b0) begin
        n_err++;
        $display("FAIL idle_write: we=%b, required 0", ifc.load_we);
      end
    end
    ifc.sample_valid = 1'b0;
  endtask

  task automatic fft_phase(input logic [NOTE_W-1:0] note, input int delay, input logic exp_load);
    logic exp_dec;
    @(negedge clk);
    n_cmp++;
    if (ifc.fft_start !== 1'b1 || led_start !== 1'b1) begin
      n_err++;
      $display("FAIL fft_start: start=%b led_start=%b, required 1 1", ifc.fft_start, led_start);
    end
    repeat (delay) begin
      @(negedge clk);
      n_cmp++;
      if (ifc.fft_start !== 1'b0 || led_start !== 1'b1) begin
        n_err++;
        $display("FAIL wait: start=%b led_start=%b, required 0 1", ifc.fft_start, led_start);
      end
    end
    ifc.fft_done = 1'b1;
    ifc.fft_note = note;
    exp_dec = model_judge(note);
    @(negedge clk);
    ifc.fft_done = 1'b0;
    ifc.fft_note = NOTE_W'($urandom);
    n_cmp++;
    if (note_out !== m_note || note_dec !== exp_dec || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL judge: note_out=%h dec=%b terr=%b, required %h %b 0", note_out, note_dec, timeout_err, m_note, exp_dec);
    end
    @(negedge clk);
    n_cmp++;
    if (led_load !== exp_load || note_dec !== 1'b0) begin
      n_err++;
      $display("FAIL after_judge: led_load=%b dec=%b, required %b 0", led_load, note_dec, exp_load);
    end
    if (!exp_load) m_hist.delete();
  endtask

  task automatic release_abort(input int start);
    logic [N-1:0]         a;
    logic [BIT_WIDTH-1:0] d;
    a = N'(start);
    btn_n = '1;
    for (int t = 1; t <= DB_CYCLES + 1; t++) begin
      d = BIT_WIDTH'($urandom);
      ifc.sample_valid = 1'b1;
      ifc.sample_in    = d;
      @(negedge clk);
      n_cmp++;
      if (t <= DB_CYCLES) begin
        if (ifc.load_we !== 1'b1 || ifc.load_addr !== a || ifc.load_data !== d) begin
          n_err++;
          $display("FAIL pre_abort_write: we=%b addr=%0d, required 1 %0d", ifc.load_we, ifc.load_addr, a);
        end
        a++;
      end else if (ifc.load_we !== 1'b0 || led_load !== 1'b0) begin
        n_err++;
        $display("FAIL abort: we=%b led_load=%b, required 0 0", ifc.load_we, led_load);
      end
    end
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (ifc.load_we !== 1'b0 || led_load !== 1'b0) begin
        n_err++;
        $display("FAIL post_abort: we=%b led_load=%b, required 0 0", ifc.load_we, led_load);
      end
    end
    ifc.sample_valid = 1'b0;
    m_hist.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({note_out, note_dec, ifc.fft_start, ifc.load_we, ifc.load_addr, ifc.load_data,
         active_btn, led_load, led_start, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset: note=%h we=%b addr=%0d data=%h btn=%0d leds=%b%b terr=%b, required all 0",
               note_out, ifc.load_we, ifc.load_addr, ifc.load_data, active_btn, led_load, led_start, timeout_err);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    mode  = 1'b0;
    btn_n = 4'b1110;
    repeat (DB_CYCLES + 1) @(negedge clk);
    load_frame(100);
    btn_n = '1;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({note_out, note_dec, ifc.fft_start, ifc.load_we, ifc.load_addr, ifc.load_data,
         active_btn, led_load, led_start, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_load: we=%b addr=%0d data=%h led_load=%b, required all 0",
               ifc.load_we, ifc.load_addr, ifc.load_data, led_load);
    end
    @(negedge clk);
    reset  = 1'b1;
    m_note = '0;
    m_hist.delete();
    ifc.sample_valid = 1'b1;
    repeat (30) begin
      ifc.sample_in = BIT_WIDTH'($urandom);
      @(negedge clk);
      n_cmp++;
      if (ifc.load_we !== 1'b0 || led_load !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_write: we=%b led_load=%b, required 0 0", ifc.load_we, led_load);
      end
    end
    ifc.sample_valid = 1'b0;
  endtask

  task automatic test_two_frames();
    btn_n = 4'b1011;
    repeat (DB_CYCLES) @(negedge clk);
    n_cmp++;
    if (led_load !== 1'b0) begin
      n_err++;
      $display("FAIL press_early: led_load=%b, required 0", led_load);
    end
    @(negedge clk);
    n_cmp++;
    if (led_load !== 1'b1 || active_btn !== 2'd2) begin
      n_err++;
      $display("FAIL press_latency: led_load=%b btn=%0d, required 1 2", led_load, active_btn);
    end
    for (int f = 0; f < 2; f++) begin
      load_frame(FFT_SIZE);
      fft_phase(8'h45, $urandom_range(0, 30), 1'b1);
    end
    n_cmp++;
    if (note_out !== 8'h45) begin
      n_err++;
      $display("FAIL two_frames_note: note_out=%h, required 45", note_out);
    end
  endtask

  task automatic test_stability();
    logic [NOTE_W-1:0] seq [4];
    seq = '{8'h45, 8'h00, 8'h47, 8'h47};
    for (int f = 0; f < 4; f++) begin
      load_frame(FFT_SIZE);
      fft_phase(seq[f], $urandom_range(0, 30), 1'b1);
    end
    n_cmp++;
    if (note_out !== 8'h47) begin
      n_err++;
      $display("FAIL stability_note: note_out=%h, required 47", note_out);
    end
    load_frame(20);
    release_abort(20);
  endtask

  task automatic test_two_buttons();
    btn_n = 4'b0101;
    repeat (DB_CYCLES + 1) @(negedge clk);
    n_cmp++;
    if (led_load !== 1'b1 || active_btn !== 2'd1) begin
      n_err++;
      $display("FAIL two_buttons: led_load=%b btn=%0d, required 1 1", led_load, active_btn);
    end
    load_frame(30);
    release_abort(30);
  endtask

  task automatic test_timeout();
    mode  = 1'b0;
    btn_n = 4'b1110;
    repeat (DB_CYCLES + 1) @(negedge clk);
    n_cmp++;
    if (led_load !== 1'b1 || active_btn !== 2'd0) begin
      n_err++;
      $display("FAIL timeout_press: led_load=%b btn=%0d, required 1 0", led_load, active_btn);
    end
    load_frame(FFT_SIZE);
    @(negedge clk);
    n_cmp++;
    if (ifc.fft_start !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_start: start=%b, required 1", ifc.fft_start);
    end
    btn_n = '1;
    repeat (TIMEOUT - 1) @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0 || led_start !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_early: terr=%b led_start=%b, required 0 1", timeout_err, led_start);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b1 || led_start !== 1'b0 || led_load !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_fire: terr=%b led_start=%b led_load=%b, required 1 0 0", timeout_err, led_start, led_load);
    end
    m_hist.delete();
    btn_n = 4'b1110;
    repeat (DB_CYCLES) @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b1 || led_load !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_sticky: terr=%b led_load=%b, required 1 0", timeout_err, led_load);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0 || led_load !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_clear: terr=%b led_load=%b, required 0 1", timeout_err, led_load);
    end
  endtask

  task automatic test_continuous();
    logic [NOTE_W-1:0] n0;
    mode  = 1'b1;
    btn_n = '1;
    n0    = rand_note();
    load_frame(FFT_SIZE);
    fft_phase(n0, TIMEOUT - 1, 1'b1);
    load_frame(FFT_SIZE);
    fft_phase(n0, $urandom_range(0, 30), 1'b1);
    load_frame(FFT_SIZE);
    fft_phase(rand_note(), $urandom_range(0, 30), 1'b1);
    load_frame(FFT_SIZE);
    mode = 1'b0;
    fft_phase(rand_note(), $urandom_range(0, 30), 1'b0);
    ifc.sample_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (led_load !== 1'b0 || ifc.load_we !== 1'b0) begin
        n_err++;
        $display("FAIL continuous_stop: led_load=%b we=%b, required 0 0", led_load, ifc.load_we);
      end
    end
    ifc.sample_valid = 1'b0;
  endtask

  initial begin
    ifc.sample_valid = 1'b0;
    ifc.sample_in    = '0;
    ifc.fft_done     = 1'b0;
    ifc.fft_note     = '0;
    test_reset();
    test_reset_mid_load();
    test_two_frames();
    test_stability();
    test_two_buttons();
    test_timeout();
    test_continuous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Parametrised frame sequencer for the note-detection path: debounces up to NUM_BTN active-low note buttons and gathers FFT_SIZE samples into the FFT input buffer. It then starts the FFT, waits for completion and runs a multi-frame stability filter on the detected note code. It sits between the ADC sample strobe and the FFT core / display decoder, replacing the single-button burst control. It adds a continuous mode, a completion timeout and a held (non-flickering) note output.

## Interface
- BIT_WIDTH, 16, sample width
- N, 9, log2 of FFT size; buffer address width
- FFT_SIZE, 512, samples per frame; must equal 2**N
- NUM_BTN, 4, number of note buttons; minimum 2
- NOTE_W, 8, note code width; code 0 = no peak
- DB_CYCLES, 1000, debounce stability window in clk cycles
- STABLE_FRAMES, 2, consecutive identical frames required to accept a note; minimum 1
- TIMEOUT, 65535, max clk cycles in WAIT before abort

- clk  in  1  system clock (HSOSC-derived)
- reset  in  1  asynchronous, active-low reset
- mode  in  1  0 = burst (frames only while button held), 1 = continuous
- btn_n  in  NUM_BTN  raw note buttons, active-low
- sample_valid  in  1  one-cycle ADC sample strobe (rate FS)
- sample_in  in  BIT_WIDTH  ADC sample
- load_we  out  1  buffer write enable
- load_addr  out  N  buffer write address
- load_data  out  BIT_WIDTH  buffer write data
- fft_start  out  1  one-cycle FFT start pulse
- fft_done  in  1  one-cycle FFT completion pulse
- fft_note  in  NOTE_W  note code from peak detector, valid with fft_done
- note_out  out  NOTE_W  last accepted note, held
- note_dec  out  1  one-cycle pulse when note_out changes
- active_btn  out  $clog2(NUM_BTN)  index of button owning the current session
- led_load, led_start  out  1 each  status LEDs
- timeout_err  out  1  sticky FFT-timeout flag

## Operation
- Debounce: per-button counter. The debounced state takes the raw value after DB_CYCLES consecutive identical samples. Reset state = released.
- FSM states: IDLE, LOAD, START, WAIT, JUDGE.
- IDLE: cand/cnt cleared. If any debounced button is pressed, latch its lowest index into active_btn, clear timeout_err, set addr=0 and go to LOAD.
- LOAD: each sample_valid writes sample_in at addr and increments addr. The write at addr FFT_SIZE-1 moves the FSM to START.
- Burst mode in LOAD: release of active_btn aborts to IDLE, with no write that cycle. This takes priority over a simultaneous sample_valid.
- START: fft_start=1 for one cycle, then WAIT. The timeout counter is cleared.
- WAIT: fft_done goes to JUDGE. The counter reaching TIMEOUT sets timeout_err and goes to IDLE. If both occur in the same cycle, fft_done wins.
- JUDGE (one cycle), stability filter:
  - If fft_note==0: cand=0, cnt=0.
  - Else if fft_note==cand: cnt=min(cnt+1, STABLE_FRAMES).
  - Else: cand=fft_note, cnt=1.
  - Accept when new cnt==STABLE_FRAMES and cand!=note_out: note_out=cand, note_dec pulse.
- After JUDGE: go to LOAD (addr=0) if mode=1 or active_btn is still pressed; otherwise go to IDLE.
- In START/WAIT/JUDGE, a button release does not abort; the current frame completes.
- note_out is never cleared except by reset. It holds through LOAD, releases and new presses.
- led_load = (state==LOAD). led_start = (state==START or WAIT).

## Timing
- Reset (async, reset=0) values:
  - State, address and counters: IDLE, addr=0, all counters 0.
  - Outputs: note_out=0, note_dec=0, fft_start=0, load_we=0, load_addr=0, load_data=0, active_btn=0, timeout_err=0, LEDs 0.
- Write path: load_we/load_addr/load_data are registered and appear 1 cycle after the sample_valid cycle.
- fft_start rises the cycle after the registered final write.
- note_dec pulses and note_out updates 1 cycle after fft_done; they change in the same cycle.
- Button latency: a raw press reaches LOAD DB_CYCLES+1 cycles after the input settles.
- Burst-mode abort: the FSM is in IDLE 1 cycle after the debounced release.

## Test plan
- Reset mid-LOAD (reset=0 at addr 100) -> all outputs return to reset values immediately. After release, no write occurs until the next debounced press.
- Hold btn_n[2] (mode=0), STABLE_FRAMES=2, fft_note=0x45 on two frames -> addresses 0..511 written each frame; active_btn=2; note_out=0x45 with one note_dec pulse after frame 2.
- Continue holding with frames 0x45, 0x00, 0x47, 0x47 -> note_out stays 0x45 through frames 3 and 4 and never reads 0. It becomes 0x47 with one note_dec after frame 6.
- Press btn 1 and 3 simultaneously -> active_btn=1. Release btn 1 mid-LOAD -> IDLE, no further writes. Release with sample_valid in the same cycle -> no write.
- Omit fft_done (TIMEOUT=200) -> timeout_err=1 at cycle 200 of WAIT, state IDLE. timeout_err clears on the next press.
- mode=1, press then release -> frames repeat back-to-back. Setting mode=0 with the button released -> IDLE after the current JUDGE.
